// File: rtl/PARAMS_pkg.sv
// Shared datapath widths for the register-file write path.
package PARAMS_pkg;
  localparam int INSTR_REG_BITS = 5;
  localparam int WD_SIZE        = 32;
endpackage

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results win every slot, memory results
// wait in a small FIFO; buffered entries overwritten by a younger ALU result are killed.
module wb_arbiter
  import PARAMS_pkg::*;
#(
  parameter int REG_NUM    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alu_valid,
  input  logic [INSTR_REG_BITS-1:0] alu_rd,
  input  logic [WD_SIZE-1:0]        alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [INSTR_REG_BITS-1:0] mem_rd,
  input  logic [WD_SIZE-1:0]        mem_data,
  output logic                      wr_en,
  output logic [INSTR_REG_BITS-1:0] wr_rd,
  output logic [WD_SIZE-1:0]        wr_data,
  output logic [REG_NUM-1:0]        pending_mask
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [FIFO_DEPTH-1:0]     live_q, live_d;
  logic [INSTR_REG_BITS-1:0] rd_q   [FIFO_DEPTH];
  logic [INSTR_REG_BITS-1:0] rd_d   [FIFO_DEPTH];
  logic [WD_SIZE-1:0]        data_q [FIFO_DEPTH];
  logic [WD_SIZE-1:0]        data_d [FIFO_DEPTH];
  logic                      wr_en_q, wr_en_d;
  logic [INSTR_REG_BITS-1:0] wr_rd_q, wr_rd_d;
  logic [WD_SIZE-1:0]        wr_data_q, wr_data_d;

  logic alu_fire, full, empty, push, pop;

  assign alu_fire  = alu_valid && (alu_rd != '0);
  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  // Ready is forced low while reset is held, independent of any clock edge.
  assign mem_ready = reset_n && !full;
  // x0 results and results already superseded by the concurrent ALU write are
  // accepted on the handshake but never stored.
  assign push      = mem_valid && mem_ready && (mem_rd != '0) &&
                     !(alu_fire && (mem_rd == alu_rd));
  assign pop       = !alu_fire && !empty;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    live_d    = live_q;
    rd_d      = rd_q;
    data_d    = data_q;
    wr_en_d   = 1'b0;
    wr_rd_d   = '0;
    wr_data_d = '0;

    if (alu_fire) begin
      wr_en_d   = 1'b1;
      wr_rd_d   = alu_rd;
      wr_data_d = alu_data;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (rd_q[i] == alu_rd) live_d[i] = 1'b0;
      end
    end else if (pop && live_q[rptr_q]) begin
      wr_en_d   = 1'b1;
      wr_rd_d   = rd_q[rptr_q];
      wr_data_d = data_q[rptr_q];
    end

    if (pop) begin
      live_d[rptr_q] = 1'b0;
      rptr_d         = rptr_q + 1'b1;
    end

    if (push) begin
      live_d[wptr_q] = 1'b1;
      rd_d[wptr_q]   = mem_rd;
      data_d[wptr_q] = mem_data;
      wptr_d         = wptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 0; r < REG_NUM; r++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (live_q[i] && (rd_q[i] == INSTR_REG_BITS'(r))) pending_mask[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      live_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      live_q    <= live_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Payload storage carries no reset; liveness is tracked by live_q alone.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  assign wr_en   = wr_en_q;
  assign wr_rd   = wr_rd_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: write-slot priority, FIFO back-pressure,
// kill-on-overwrite, x0 handling and asynchronous reset.
module tb_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [31:0] pending_mask;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.REG_NUM(32), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .wr_en        (wr_en),
    .wr_rd        (wr_rd),
    .wr_data      (wr_data),
    .pending_mask (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_rd    = '0;
    mem_data  = '0;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".wr_en"}, 64'(wr_en), 64'(en));
    chk({tag, ".wr_rd"}, 64'(wr_rd), 64'(rd));
    chk({tag, ".wr_data"}, 64'(wr_data), 64'(d));
  endtask

  initial begin
    int  idx;
    logic acc;
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_wr("rst", 1'b0, 5'd0, 32'h0);
    chk("rst.pending", 64'(pending_mask), 64'h0);
    chk("rst.mem_ready", 64'(mem_ready), 64'h0);
    reset_n = 1'b1;
    #1;
    chk("rel.mem_ready", 64'(mem_ready), 64'h1);

    // Single memory result: pending after edge 1, written after edge 2.
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hAAAA5555;
    step();
    idle();
    chk("t1.pending", 64'(pending_mask), 64'h20);
    chk("t1.wr_en_e1", 64'(wr_en), 64'h0);
    step();
    chk_wr("t1.e2", 1'b1, 5'd5, 32'hAAAA5555);
    chk("t1.pending_e2", 64'(pending_mask), 64'h0);
    step();
    chk("t1.wr_en_e3", 64'(wr_en), 64'h0);

    // ALU busy for 8 cycles while 6 memory results are offered.
    idx = 0;
    for (int k = 0; k < 14; k++) begin
      alu_valid = (k < 8);
      alu_rd    = (k < 8) ? 5'(k + 1) : 5'd0;
      alu_data  = (k < 8) ? 32'h100 + 32'(k) : 32'h0;
      mem_valid = (idx < 6);
      mem_rd    = 5'(10 + idx);
      mem_data  = 32'h200 + 32'(idx);
      #1;
      chk($sformatf("t2.ready[%0d]", k), 64'(mem_ready), 64'((k < 4) || (k >= 9)));
      acc = mem_valid && mem_ready;
      step();
      if (acc) idx++;
      if (k < 8) chk_wr($sformatf("t2.alu[%0d]", k), 1'b1, 5'(k + 1), 32'h100 + 32'(k));
      else       chk_wr($sformatf("t2.mem[%0d]", k), 1'b1, 5'(10 + k - 8), 32'h200 + 32'(k - 8));
    end
    chk("t2.accepted", 64'(idx), 64'd6);
    idle();
    step();
    chk("t2.wr_en_end", 64'(wr_en), 64'h0);
    chk("t2.pending_end", 64'(pending_mask), 64'h0);

    // Kill: rd7 buffered, then overwritten by ALU before it drains.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
    step();
    chk("t3.pend_a", 64'(pending_mask), 64'h80);
    alu_rd = 5'd2; alu_data = 32'h2;
    mem_rd = 5'd9; mem_data = 32'h99;
    step();
    chk("t3.pend_b", 64'(pending_mask), 64'h280);
    mem_valid = 1'b0;
    alu_rd = 5'd7; alu_data = 32'h70;
    step();
    idle();
    chk_wr("t3.alu7", 1'b1, 5'd7, 32'h70);
    chk("t3.pend_c", 64'(pending_mask), 64'h200);
    step();
    chk("t3.killed_slot", 64'(wr_en), 64'h0);
    chk("t3.pend_d", 64'(pending_mask), 64'h200);
    step();
    chk_wr("t3.rd9", 1'b1, 5'd9, 32'h99);
    chk("t3.pend_e", 64'(pending_mask), 64'h0);
    step();
    chk("t3.wr_en_f", 64'(wr_en), 64'h0);

    // Same-cycle ALU and memory result to the same register.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h22;
    #1;
    chk("t4.ready", 64'(mem_ready), 64'h1);
    step();
    idle();
    chk_wr("t4.wr", 1'b1, 5'd3, 32'h11);
    chk("t4.pending", 64'(pending_mask), 64'h0);
    step();
    chk("t4.no_drain", 64'(wr_en), 64'h0);

    // x0 destinations from both sources.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h44;
    step();
    idle();
    chk("t5.wr_en", 64'(wr_en), 64'h0);
    chk("t5.pending", 64'(pending_mask), 64'h0);
    chk("t5.ready", 64'(mem_ready), 64'h1);
    step();
    chk("t5.wr_en2", 64'(wr_en), 64'h0);

    // Asynchronous reset with three entries buffered.
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(k + 1); alu_data = 32'h500 + 32'(k);
      mem_valid = 1'b1; mem_rd = 5'(20 + k); mem_data = 32'h600 + 32'(k);
      step();
    end
    idle();
    chk("t6.pend_pre", 64'(pending_mask), 64'h0070_0000);
    chk("t6.wr_en_pre", 64'(wr_en), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6.wr_en_async", 64'(wr_en), 64'h0);
    chk("t6.pend_async", 64'(pending_mask), 64'h0);
    chk("t6.ready_async", 64'(mem_ready), 64'h0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    chk("t6.ready_rel", 64'(mem_ready), 64'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t6.stale[%0d]", k), 64'(wr_en), 64'h0);
      chk($sformatf("t6.pend[%0d]", k), 64'(pending_mask), 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
